// File: rtl/ct_add_sched_pkg.sv
// Shared types and constants for the ciphertext-addition scheduler.
// Monitors import this package to decode the FSM state.
package ct_add_sched_pkg;

  localparam int N_SLOTS_L = 8;
  localparam int W_BITS_L  = 16;
  localparam logic [W_BITS_L-1:0] Q_MOD = 16'd7710;

  typedef logic [N_SLOTS_L-1:0][W_BITS_L-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
  } CT_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2,
    DONE  = 2'd3
  } ct_add_state_t;

  // Round-robin pick between two requesters: a lone requester wins,
  // a tie goes to whoever did not win last time.
  function automatic logic rrPick(input logic [1:0] valid, input logic lastGrant);
    if (valid == 2'b11) begin
      return ~lastGrant;
    end else if (valid[0]) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/ct_add_sched_if.sv
// Request/response bundle between the two requesters, the consumer
// and the shared adder. The requester/consumer side uses master.
interface ct_add_sched_if;
  import ct_add_sched_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  CT_t  [1:0]      req_ct1;
  CT_t  [1:0]      req_ct2;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_id;
  CT_t             resp_ct;
  logic            busy;

  modport master (
    output req_valid, req_ct1, req_ct2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_ct, busy
  );

  modport slave (
    input  req_valid, req_ct1, req_ct2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_ct, busy
  );

endinterface

// File: rtl/ct_add_sched_add_mod_q.sv
// Single-slot modular adder: (a + b) mod q for operands already below q.
// Out-of-range operands get the same single conditional subtraction.
module add_mod_q
  import ct_add_sched_pkg::*;
#(
  parameter int W = W_BITS_L
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_qp,
  output logic [W-1:0] o_sum
);

  logic [W:0] w_s;
  logic [W:0] w_q;

  // Widen by one bit so the carry is kept, then subtract q once if needed.
  always_comb begin
    w_s   = {1'b0, i_a} + {1'b0, i_b};
    w_q   = {1'b0, i_qp};
    o_sum = W'((w_s >= w_q) ? (w_s - w_q) : w_s);
  end

endmodule

// File: rtl/ct_add_sched.sv
// Shared ciphertext adder for two requesters. Arbitrates round-robin,
// captures the winner's operands, adds them LANES slots per cycle over
// the A vector then the B vector, and returns the sum tagged with the id.
module ct_add_sched
  import ct_add_sched_pkg::*;
#(
  parameter int LANES = 2,
  parameter logic [W_BITS_L-1:0] QP = Q_MOD
) (
  input  logic           clk,
  input  logic           rst_n,
  ct_add_sched_if.slave  bus
);

  localparam int SLOT_W = $clog2(N_SLOTS_L);
  localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(N_SLOTS_L - LANES);
  localparam logic [SLOT_W-1:0] STEP     = SLOT_W'(LANES);

  if ((LANES < 1) || ((N_SLOTS_L % LANES) != 0)) begin : g_lanesCheck
    $error("ct_add_sched: LANES must divide N_SLOTS_L");
  end

  ct_add_state_t       r_state;
  ct_add_state_t       w_nextState;
  logic                r_lastGrant;
  logic                r_id;
  logic [SLOT_W-1:0]   r_idx;
  CT_t                 r_op1;
  CT_t                 r_op2;
  CT_t                 r_resp;

  logic                w_grant;
  logic                w_anyValid;
  logic                w_accept;
  logic                w_lastSlot;
  logic [1:0]          w_reqReady;

  logic [SLOT_W-1:0]   w_slot    [LANES];
  logic [W_BITS_L-1:0] w_laneA   [LANES];
  logic [W_BITS_L-1:0] w_laneB   [LANES];
  logic [W_BITS_L-1:0] w_laneSum [LANES];

  // Arbitration and the one-hot ready, which is only ever offered in IDLE.
  always_comb begin
    w_anyValid = |bus.req_valid;
    w_grant    = rrPick(bus.req_valid, r_lastGrant);
    w_accept   = (r_state == IDLE) && w_anyValid;
    w_reqReady = 2'b00;
    if (w_accept) begin
      w_reqReady[w_grant] = 1'b1;
    end
  end

  // Slot walk: the last step of a vector is the one that starts at N-LANES.
  always_comb begin
    w_lastSlot = (r_idx == LAST_IDX);
  end

  // Lane k works on slot idx+k of whichever vector is being processed.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_slot[k] = r_idx + SLOT_W'(k);
      if (r_state == RUN_B) begin
        w_laneA[k] = r_op1.b[w_slot[k]];
        w_laneB[k] = r_op2.b[w_slot[k]];
      end else begin
        w_laneA[k] = r_op1.a[w_slot[k]];
        w_laneB[k] = r_op2.a[w_slot[k]];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    add_mod_q #(
      .W (W_BITS_L)
    ) u_addModQ (
      .i_a   (w_laneA[g]),
      .i_b   (w_laneB[g]),
      .i_qp  (QP),
      .o_sum (w_laneSum[g])
    );
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: accept, walk A, walk B, then wait for the consumer.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_nextState = RUN_A;
      RUN_A:   if (w_lastSlot)     w_nextState = RUN_B;
      RUN_B:   if (w_lastSlot)     w_nextState = DONE;
      DONE:    if (bus.resp_ready) w_nextState = IDLE;
      default:                     w_nextState = IDLE;
    endcase
  end

  // Operand capture, arbitration history, slot index and result vectors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op1       <= '0;
      r_op2       <= '0;
      r_resp      <= '0;
      r_id        <= 1'b0;
      r_lastGrant <= 1'b1;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op1       <= bus.req_ct1[w_grant];
            r_op2       <= bus.req_ct2[w_grant];
            r_id        <= w_grant;
            r_lastGrant <= w_grant;
            r_idx       <= '0;
          end
        end
        RUN_A: begin
          for (int k = 0; k < LANES; k++) begin
            r_resp.a[w_slot[k]] <= w_laneSum[k];
          end
          r_idx <= w_lastSlot ? '0 : (r_idx + STEP);
        end
        RUN_B: begin
          for (int k = 0; k < LANES; k++) begin
            r_resp.b[w_slot[k]] <= w_laneSum[k];
          end
          r_idx <= w_lastSlot ? '0 : (r_idx + STEP);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = w_reqReady;
  assign bus.resp_valid = (r_state == DONE);
  assign bus.resp_id    = r_id;
  assign bus.resp_ct    = r_resp;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ct_add_sched.sv
// Bench for ct_add_sched: the main instance uses LANES=2; two extra
// instances with LANES=1 and LANES=8 share the request inputs so their
// results and latencies can be compared on the same data.
module tb_ct_add_sched;
  import ct_add_sched_pkg::*;

  localparam int QI = 7710;

  logic       clk = 1'b0;
  logic       rstN;
  logic [1:0] reqValid;
  logic       respReady;
  logic       auxReady;
  CT_t        op1 [2];
  CT_t        op2 [2];

  int   total = 0;
  int   bad   = 0;
  int   modelLast;
  CT_t  expCt;
  int   expId;

  int s1In1A[8] = '{1429, 4717, 6311, 3279, 7215, 6215, 6931, 973};
  int s1In2A[8] = '{1081, 592, 951, 5762, 2873, 4, 152, 3013};
  int s1In1B[8] = '{7531, 4381, 1094, 7529, 5909, 964, 5576, 4640};
  int s1In2B[8] = '{1577, 3917, 6039, 6187, 2056, 6280, 1531, 7656};
  int s1ExpA[8] = '{2510, 5309, 7262, 1331, 2378, 6219, 7083, 3986};
  int s1ExpB[8] = '{1398, 588, 7133, 6006, 255, 7244, 7107, 4586};
  int bndX[5]   = '{7709, 7709, 0, 3855, 7000};
  int bndY[5]   = '{1, 7709, 0, 3855, 709};
  int bndR[5]   = '{0, 7708, 0, 0, 7709};

  always #5 clk = ~clk;

  ct_add_sched_if busM ();
  ct_add_sched_if busL1 ();
  ct_add_sched_if busL8 ();

  assign busM.req_valid   = reqValid;
  assign busM.req_ct1     = {op1[1], op1[0]};
  assign busM.req_ct2     = {op2[1], op2[0]};
  assign busM.resp_ready  = respReady;
  assign busL1.req_valid  = reqValid;
  assign busL1.req_ct1    = {op1[1], op1[0]};
  assign busL1.req_ct2    = {op2[1], op2[0]};
  assign busL1.resp_ready = auxReady;
  assign busL8.req_valid  = reqValid;
  assign busL8.req_ct1    = {op1[1], op1[0]};
  assign busL8.req_ct2    = {op2[1], op2[0]};
  assign busL8.resp_ready = auxReady;

  ct_add_sched #(.LANES(2)) dut   (.clk(clk), .rst_n(rstN), .bus(busM));
  ct_add_sched #(.LANES(1)) dutL1 (.clk(clk), .rst_n(rstN), .bus(busL1));
  ct_add_sched #(.LANES(8)) dutL8 (.clk(clk), .rst_n(rstN), .bus(busL8));

  // Reference: slot-wise (a+b) mod q on plain integers.
  function automatic CT_t modelAdd(input CT_t x, input CT_t y);
    CT_t r;
    int  s;
    for (int i = 0; i < 8; i++) begin
      s = int'(x.a[i]) + int'(y.a[i]);
      if (s >= QI) s = s - QI;
      r.a[i] = 16'(s);
      s = int'(x.b[i]) + int'(y.b[i]);
      if (s >= QI) s = s - QI;
      r.b[i] = 16'(s);
    end
    return r;
  endfunction

  function automatic CT_t randCt();
    CT_t r;
    for (int i = 0; i < 8; i++) begin
      r.a[i] = 16'($urandom_range(QI - 1));
      r.b[i] = 16'($urandom_range(QI - 1));
    end
    return r;
  endfunction

  function automatic CT_t fromArrays(input int a[8], input int b[8]);
    CT_t r;
    for (int i = 0; i < 8; i++) begin
      r.a[i] = 16'(a[i]);
      r.b[i] = 16'(b[i]);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    modelLast = 1;
  endtask

  // Wait for a grant with the current valids; check it against the arbiter model.
  task automatic applyStimulus(output int gid);
    bit done;
    int e;
    done = 0;
    gid  = -1;
    for (int w = 0; w < 40 && !done; w++) begin
      #1;
      if (busM.req_ready != 2'b00) begin
        e = (reqValid == 2'b11) ? (1 - modelLast) : (reqValid[0] ? 0 : 1);
        checkOutput("grant", busM.req_ready, 2'b01 << e);
        gid       = e;
        modelLast = e;
        expId     = e;
        expCt     = modelAdd(op1[e], op2[e]);
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) checkOutput("handshakeTimeout", 0, 1);
  endtask

  // Follow a transaction from handshake to response handshake.
  task automatic finishTxn(input bit keepValid, input int hold,
                           output int lat, output logic gotId, output CT_t gotCt);
    bit seen;
    seen  = 0;
    lat   = -1;
    gotId = 1'b0;
    gotCt = '0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (keepValid) begin
          op1[expId] = randCt();
          op2[expId] = randCt();
        end else begin
          reqValid = 2'b00;
        end
      end
      #1;
      if (busM.resp_valid) begin
        seen = 1;
        lat  = k;
      end else begin
        checkOutput("busyWhileRunning", busM.busy, 1);
        checkOutput("readyWhileBusy", busM.req_ready, 0);
      end
    end
    if (!seen) begin
      checkOutput("respTimeout", 0, 1);
      return;
    end
    gotId = busM.resp_id;
    gotCt = busM.resp_ct;
    checkOutput("respCt", busM.resp_ct, expCt);
    checkOutput("respId", busM.resp_id, expId);
    checkOutput("readyInDone", busM.req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      checkOutput("holdValid", busM.resp_valid, 1);
      checkOutput("holdCt", busM.resp_ct, expCt);
      checkOutput("holdId", busM.resp_id, expId);
      checkOutput("holdReady", busM.req_ready, 0);
      checkOutput("holdBusy", busM.busy, 1);
    end
    respReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
    #1;
    checkOutput("validAfterResp", busM.resp_valid, 0);
    checkOutput("busyAfterResp", busM.busy, 0);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout: simulation did not end");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int   gid, lat, latM, lat1, lat8;
    logic gotId;
    CT_t  gotCt, ct1, ct8, specCt;
    int   order[3] = '{0, 1, 0};

    rstN      = 1'b1;
    reqValid  = 2'b00;
    respReady = 1'b0;
    auxReady  = 1'b0;
    op1[0] = '0; op1[1] = '0; op2[0] = '0; op2[1] = '0;
    modelLast = 1;

    doReset();
    #1;
    checkOutput("rstRespValid", busM.resp_valid, 0);
    checkOutput("rstBusy", busM.busy, 0);
    checkOutput("rstRespCt", busM.resp_ct, 0);
    checkOutput("rstRespId", busM.resp_id, 0);
    checkOutput("rstReqReady", busM.req_ready, 0);

    // Scenario-1 data on all three lane widths at once.
    $display("[TB] known-vector request on requester 0, LANES 1/2/8");
    op1[0] = fromArrays(s1In1A, s1In1B);
    op2[0] = fromArrays(s1In2A, s1In2B);
    specCt = fromArrays(s1ExpA, s1ExpB);
    reqValid = 2'b01;
    applyStimulus(gid);
    latM = -1; lat1 = -1; lat8 = -1;
    ct1 = '0; ct8 = '0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) reqValid = 2'b00;
      #1;
      if (busM.resp_valid && latM < 0) begin
        latM = k;
        checkOutput("s1Ct", busM.resp_ct, specCt);
        checkOutput("s1Id", busM.resp_id, 0);
      end
      if (busL1.resp_valid && lat1 < 0) begin lat1 = k; ct1 = busL1.resp_ct; end
      if (busL8.resp_valid && lat8 < 0) begin lat8 = k; ct8 = busL8.resp_ct; end
    end
    checkOutput("s1Latency", latM, 9);
    checkOutput("lanes1Latency", lat1, 17);
    checkOutput("lanes8Latency", lat8, 3);
    checkOutput("lanes1Ct", ct1, specCt);
    checkOutput("lanes8Ct", ct8, specCt);
    checkOutput("lanes1Id", busL1.resp_id, 0);
    checkOutput("lanes8Id", busL8.resp_id, 0);
    respReady = 1'b1;
    auxReady  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    respReady = 1'b0;
    auxReady  = 1'b0;
    #1;
    checkOutput("s1BusyAfter", busM.busy, 0);

    // Both requesters valid for three back-to-back transactions.
    $display("[TB] contention: both requesters valid");
    doReset();
    op1[0] = randCt(); op2[0] = randCt();
    op1[1] = randCt(); op2[1] = randCt();
    reqValid = 2'b11;
    for (int t = 0; t < 3; t++) begin
      applyStimulus(gid);
      finishTxn(1'b1, 0, lat, gotId, gotCt);
      checkOutput("contentionOrder", gotId, order[t]);
      checkOutput("contentionLatency", lat, 9);
    end

    // Slots sitting on the modulus boundaries.
    $display("[TB] boundary slots");
    op1[0] = randCt(); op2[0] = randCt();
    for (int i = 0; i < 5; i++) begin
      op1[0].a[i]     = 16'(bndX[i]);
      op2[0].a[i]     = 16'(bndY[i]);
      op1[0].b[i + 3] = 16'(bndX[i]);
      op2[0].b[i + 3] = 16'(bndY[i]);
    end
    reqValid = 2'b01;
    applyStimulus(gid);
    finishTxn(1'b0, 0, lat, gotId, gotCt);
    for (int i = 0; i < 5; i++) begin
      checkOutput("boundaryA", gotCt.a[i], bndR[i]);
      checkOutput("boundaryB", gotCt.b[i + 3], bndR[i]);
    end

    // Consumer backpressure for six cycles in DONE.
    $display("[TB] response backpressure");
    op1[1] = randCt(); op2[1] = randCt();
    reqValid = 2'b10;
    applyStimulus(gid);
    finishTxn(1'b0, 6, lat, gotId, gotCt);
    checkOutput("backpressureId", gotId, 1);

    // Random masks, operands and hold times.
    $display("[TB] random transactions");
    for (int t = 0; t < 10; t++) begin
      op1[0] = randCt(); op2[0] = randCt();
      op1[1] = randCt(); op2[1] = randCt();
      reqValid = 2'($urandom_range(3, 1));
      applyStimulus(gid);
      finishTxn(1'b0, $urandom_range(3), lat, gotId, gotCt);
      checkOutput("randLatency", lat, 9);
    end

    // Reset while walking the B vector, then a fresh contest.
    $display("[TB] reset during RUN_B");
    op1[0] = randCt(); op2[0] = randCt();
    reqValid = 2'b01;
    applyStimulus(gid);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) reqValid = 2'b00;
    end
    #1;
    checkOutput("busyBeforeReset", busM.busy, 1);
    rstN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    modelLast = 1;
    #1;
    checkOutput("midRstRespValid", busM.resp_valid, 0);
    checkOutput("midRstBusy", busM.busy, 0);
    checkOutput("midRstRespCt", busM.resp_ct, 0);
    op1[0] = randCt(); op2[0] = randCt();
    op1[1] = randCt(); op2[1] = randCt();
    reqValid = 2'b11;
    applyStimulus(gid);
    finishTxn(1'b0, 0, lat, gotId, gotCt);
    checkOutput("postRstGrantId", gotId, 0);
    checkOutput("postRstLatency", lat, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
